// File: rtl/hub75_stream_writer.sv
// hub75_stream_writer
// Feeds a raster-ordered pixel stream into the HUB75 write-in stage's
// double-buffered line buffer. Pixels are written one per accepted beat;
// when a line is complete the block waits for the write-in stage to go idle,
// then pulses swap + store for that line and moves to the next line.
// A start-of-frame flag on an accepted pixel forces that pixel to (col 0,
// line 0); arriving anywhere else flags a one-cycle sync error.
//
// Optional feature macro: HUB75_STREAM_RGB565_EN
//   defined   : in_data is 16-bit RGB565, expanded to 8 bits per channel by
//               MSB replication into wr_data {B,G,R}
//   undefined : in_data passes through unchanged
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_data/in_sof/in_valid/in_ready   pixel stream (valid/ready)
//   wr_data/wr_col_addr/wr_en          line-buffer write port
//   wr_bank_addr/wr_row_addr           line being committed
//   wr_row_store/wr_row_swap           one-cycle commit pulses
//   wr_row_rdy                         write-in stage idle
//   frame_done                         last line of a frame committed
//   err_sync                           start-of-frame misalignment
module hub75_stream_writer #(
   parameter int unsigned N_BANKS     = 2,
   parameter int unsigned N_ROWS      = 32,
   parameter int unsigned N_COLS      = 64,
   parameter int unsigned N_CHANS     = 3,
   parameter int unsigned N_PLANES    = 8,
   parameter int unsigned LOG_N_BANKS = $clog2(N_BANKS),
   parameter int unsigned LOG_N_ROWS  = $clog2(N_ROWS),
   parameter int unsigned LOG_N_COLS  = $clog2(N_COLS),
`ifdef HUB75_STREAM_RGB565_EN
   localparam int unsigned IN_W       = 16,
`else
   localparam int unsigned IN_W       = N_CHANS * N_PLANES,
`endif
   localparam int unsigned DW         = N_CHANS * N_PLANES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IN_W-1:0]        in_data,
   input  logic                   in_sof,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [LOG_N_BANKS-1:0] wr_bank_addr,
   output logic [LOG_N_ROWS-1:0]  wr_row_addr,
   output logic                   wr_row_store,
   input  logic                   wr_row_rdy,
   output logic                   wr_row_swap,
   output logic [DW-1:0]          wr_data,
   output logic [LOG_N_COLS-1:0]  wr_col_addr,
   output logic                   wr_en,
   output logic                   frame_done,
   output logic                   err_sync
);

   localparam int unsigned YW     = LOG_N_BANKS + LOG_N_ROWS;
   localparam int unsigned LAST_Y = N_BANKS * N_ROWS - 1;
   localparam int unsigned LAST_C = N_COLS - 1;

   typedef enum logic [1:0] {
      S_FILL,
      S_WAIT,
      S_COMMIT
   } state_e;

   state_e                  state_q, state_d;
   logic [LOG_N_COLS-1:0]   col_q, col_d;
   logic [YW-1:0]           y_q, y_d;
   logic [YW-1:0]           wr_y_q, wr_y_d;
   logic                    in_ready_q, in_ready_d;
   logic                    wr_en_q, wr_en_d;
   logic [DW-1:0]           wr_data_q, wr_data_d;
   logic [LOG_N_COLS-1:0]   wr_col_q, wr_col_d;
   logic                    store_q, store_d;
   logic                    frame_done_q, frame_done_d;
   logic                    err_sync_q, err_sync_d;

   logic                    accept_c;
   logic [LOG_N_COLS-1:0]   pix_col_c;
   logic [DW-1:0]           pix_c;

   assign accept_c  = in_valid & in_ready_q;
   // start-of-frame pixels always land in column 0
   assign pix_col_c = in_sof ? '0 : col_q;

   // Input pixel formatting
`ifdef HUB75_STREAM_RGB565_EN
   assign pix_c = DW'({in_data[4:0],   in_data[4:2],
                       in_data[10:5],  in_data[10:9],
                       in_data[15:11], in_data[15:13]});
`else
   assign pix_c = in_data;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      y_d          = y_q;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      wr_col_d     = wr_col_q;
      store_d      = 1'b0;
      frame_done_d = 1'b0;
      err_sync_d   = 1'b0;

      unique case (state_q)
         S_FILL: begin
            if (accept_c) begin
               wr_en_d   = 1'b1;
               wr_data_d = pix_c;
               wr_col_d  = pix_col_c;
               col_d     = pix_col_c + LOG_N_COLS'(1);
               if (in_sof) begin
                  err_sync_d = (col_q != '0) || (y_q != '0);
                  y_d        = '0;
               end
               if (pix_col_c == LOG_N_COLS'(LAST_C)) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // commit pulses are registered, so they are raised on entry
            if (wr_row_rdy) begin
               state_d      = S_COMMIT;
               store_d      = 1'b1;
               frame_done_d = (y_q == YW'(LAST_Y));
            end
         end
         S_COMMIT: begin
            state_d = S_FILL;
            col_d   = '0;
            y_d     = (y_q == YW'(LAST_Y)) ? '0 : y_q + YW'(1);
         end
         default: begin
            state_d = S_FILL;
         end
      endcase

      in_ready_d = (state_d == S_FILL);
      wr_y_d     = y_d;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FILL;
         col_q        <= '0;
         y_q          <= '0;
         wr_y_q       <= '0;
         in_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
         wr_col_q     <= '0;
         store_q      <= 1'b0;
         frame_done_q <= 1'b0;
         err_sync_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         y_q          <= y_d;
         wr_y_q       <= wr_y_d;
         in_ready_q   <= in_ready_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         wr_col_q     <= wr_col_d;
         store_q      <= store_d;
         frame_done_q <= frame_done_d;
         err_sync_q   <= err_sync_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign wr_en        = wr_en_q;
   assign wr_data      = wr_data_q;
   assign wr_col_addr  = wr_col_q;
   assign wr_bank_addr = wr_y_q[YW-1 -: LOG_N_BANKS];
   assign wr_row_addr  = wr_y_q[LOG_N_ROWS-1:0];
   assign wr_row_store = store_q;
   assign wr_row_swap  = store_q;
   assign frame_done   = frame_done_q;
   assign err_sync     = err_sync_q;

endmodule

// File: tb/tb_hub75_stream_writer.sv
// Testbench for hub75_stream_writer (N_BANKS=2, N_ROWS=4, N_COLS=8).
// A transaction-level model turns every accepted pixel into an expected
// line-buffer write and, at the end of each line, an expected commit; a
// monitor matches DUT activity against those queues.
module tb_hub75_stream_writer;

   localparam int NB = 2;
   localparam int NR = 4;
   localparam int NC = 8;
`ifdef HUB75_STREAM_RGB565_EN
   localparam int IW = 16;
`else
   localparam int IW = 24;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [IW-1:0] in_data;
   logic          in_sof;
   logic          in_valid;
   logic          in_ready;
   logic          wr_bank_addr;
   logic [1:0]    wr_row_addr;
   logic          wr_row_store;
   logic          wr_row_rdy;
   logic          wr_row_swap;
   logic [23:0]   wr_data;
   logic [2:0]    wr_col_addr;
   logic          wr_en;
   logic          frame_done;
   logic          err_sync;

   always #5 clk = ~clk;

   hub75_stream_writer #(
      .N_BANKS (NB),
      .N_ROWS  (NR),
      .N_COLS  (NC),
      .N_CHANS (3),
      .N_PLANES(8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_sof      (in_sof),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .wr_bank_addr(wr_bank_addr),
      .wr_row_addr (wr_row_addr),
      .wr_row_store(wr_row_store),
      .wr_row_rdy  (wr_row_rdy),
      .wr_row_swap (wr_row_swap),
      .wr_data     (wr_data),
      .wr_col_addr (wr_col_addr),
      .wr_en       (wr_en),
      .frame_done  (frame_done),
      .err_sync    (err_sync)
   );

   typedef struct { int col; logic [23:0] data; } wr_t;
   typedef struct { int bank; int row; bit fd; } cm_t;
   typedef struct {
      string name;
      int    npix;
      int    sof_idx;
      int    vmode;     // 0 continuous, 1 toggling, 2 random
      int    rdy_low;   // cycles wr_row_rdy held low, -1 random
      int    exp_wr;
      int    exp_cm;
      int    exp_err;
      int    exp_fd;
   } vec_t;

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   logic rdy_smp = 1'b0;

   wr_t exp_wr_q[$];
   cm_t exp_cm_q[$];
   int  exp_err = 0;
   int  mcol = 0;
   int  my   = 0;
   int  acc_cyc[$];
   int  store_cyc[$];
   int  obs_wr = 0, obs_cm = 0, obs_err = 0, obs_fd = 0;
   int  last_wr_col = -1;
   vec_t vecs[6];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
      end
   endfunction

   // Pixel value the line buffer should receive
   function automatic logic [23:0] expand(input logic [IW-1:0] d);
`ifdef HUB75_STREAM_RGB565_EN
      int r, g, b;
      r = int'(d[15:11]);
      g = int'(d[10:5]);
      b = int'(d[4:0]);
      return {8'((b << 3) | (b >> 2)), 8'((g << 2) | (g >> 4)), 8'((r << 3) | (r >> 2))};
`else
      return d;
`endif
   endfunction

   task automatic model_clear();
      exp_wr_q.delete();
      exp_cm_q.delete();
      acc_cyc.delete();
      store_cyc.delete();
      exp_err = 0;
      mcol = 0;
      my = 0;
      obs_wr = 0; obs_cm = 0; obs_err = 0; obs_fd = 0;
      last_wr_col = -1;
   endtask

   task automatic model_accept(input logic [IW-1:0] d, input logic sof);
      wr_t w;
      cm_t c;
      if (sof) begin
         if (mcol != 0 || my != 0) exp_err++;
         mcol = 0;
         my = 0;
      end
      w.col = mcol;
      w.data = expand(d);
      exp_wr_q.push_back(w);
      acc_cyc.push_back(cyc);
      if (mcol == NC - 1) begin
         c.bank = my / NR;
         c.row  = my % NR;
         c.fd   = (my == NB * NR - 1);
         exp_cm_q.push_back(c);
         mcol = 0;
         my = (my + 1) % (NB * NR);
      end else begin
         mcol++;
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rdy_smp <= wr_row_rdy;
   end

   // Reference model: observes handshakes
   initial forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1)
         model_accept(in_data, in_sof);
   end

   // Monitor: matches DUT outputs against model expectations
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
         if (exp_cm_q.size() > 0) chk("ready_while_line_full", 64'(in_ready), 64'(0));
         if (wr_en) begin
            chk("wr_expected", 64'(exp_wr_q.size() > 0), 64'(1));
            if (exp_wr_q.size() > 0) begin
               wr_t e;
               e = exp_wr_q.pop_front();
               chk("wr_col", 64'(wr_col_addr), 64'(e.col));
               chk("wr_data", 64'(wr_data), 64'(e.data));
            end
            obs_wr++;
            last_wr_col = int'(wr_col_addr);
         end
         if (wr_row_store || wr_row_swap) begin
            chk("swap_eq_store", 64'(wr_row_swap), 64'(wr_row_store));
            chk("commit_rdy", 64'(rdy_smp), 64'(1));
            chk("commit_expected", 64'(exp_cm_q.size() > 0), 64'(1));
            if (exp_cm_q.size() > 0) begin
               cm_t e;
               e = exp_cm_q.pop_front();
               chk("cm_bank", 64'(wr_bank_addr), 64'(e.bank));
               chk("cm_row", 64'(wr_row_addr), 64'(e.row));
               chk("cm_frame_done", 64'(frame_done), 64'(e.fd));
            end
            obs_cm++;
            if (frame_done) obs_fd++;
            store_cyc.push_back(cyc);
         end else if (frame_done) begin
            chk("fd_needs_store", 64'(wr_row_store), 64'(1));
         end
         if (err_sync) begin
            chk("err_expected", 64'(exp_err > 0), 64'(1));
            if (exp_err > 0) exp_err--;
            obs_err++;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_sof = 1'b0;
      wr_row_rdy = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive_pixels(input int npix, input int sof_idx, input int vmode, input int rdy_low);
      int idx;
      int c;
      bit v;
      logic [IW-1:0] d;
      idx = 0;
      c = 0;
      d = IW'($urandom);
      while (idx < npix) begin
         @(negedge clk);
         case (vmode)
            0: v = 1'b1;
            1: v = (c % 2 == 0);
            default: v = ($urandom_range(0, 9) < 7);
         endcase
         in_valid = v;
         in_data = d;
         in_sof = (idx == sof_idx);
         wr_row_rdy = (rdy_low < 0) ? ($urandom_range(0, 3) != 0) : (c >= rdy_low);
         if (v && in_ready) begin
            idx++;
            d = IW'($urandom);
         end
         c++;
         if (c > npix * 20 + 200) begin
            chk("drive_timeout", 64'(idx), 64'(npix));
            break;
         end
      end
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid = 1'b0;
      in_sof = 1'b0;
      wr_row_rdy = 1'b1;
      repeat (6) @(negedge clk);
      chk("drain_wr_left", 64'(exp_wr_q.size()), 64'(0));
      chk("drain_cm_left", 64'(exp_cm_q.size()), 64'(0));
      chk("drain_err_left", 64'(exp_err), 64'(0));
   endtask

   task automatic check_zero(input string p);
      chk({p, "_in_ready"}, 64'(in_ready), 64'(0));
      chk({p, "_wr_en"}, 64'(wr_en), 64'(0));
      chk({p, "_store"}, 64'(wr_row_store), 64'(0));
      chk({p, "_swap"}, 64'(wr_row_swap), 64'(0));
      chk({p, "_frame_done"}, 64'(frame_done), 64'(0));
      chk({p, "_err_sync"}, 64'(err_sync), 64'(0));
      chk({p, "_wr_data"}, 64'(wr_data), 64'(0));
      chk({p, "_wr_col"}, 64'(wr_col_addr), 64'(0));
      chk({p, "_bank"}, 64'(wr_bank_addr), 64'(0));
      chk({p, "_row"}, 64'(wr_row_addr), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IW-1:0] pix;
      logic [23:0]   pix_exp;

      rst_n = 1'b0;
      in_valid = 1'b0;
      in_sof = 1'b0;
      in_data = '0;
      wr_row_rdy = 1'b0;

      vecs[0] = '{"full_frame",  64,  0, 0,  0, 64, 8, 0, 1};
      vecs[1] = '{"gapped",      24,  0, 1,  0, 24, 3, 0, 0};
      vecs[2] = '{"resync",      19, 18, 0,  0, 19, 2, 1, 0};
      vecs[3] = '{"early_sof",   11,  3, 0,  0, 11, 1, 1, 0};
      vecs[4] = '{"sof_at_wrap", 72, 64, 0,  0, 72, 9, 0, 1};
      vecs[5] = '{"rdy_held",    16,  0, 0, 30, 16, 2, 0, 0};

      // Reset state and first in_ready edge
      repeat (2) @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      chk("rdy_before_edge", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1 chk("rdy_after_edge", 64'(in_ready), 64'(1));

      // Table-driven scenarios
      for (int i = 0; i < 6; i++) begin
         do_reset();
         drive_pixels(vecs[i].npix, vecs[i].sof_idx, vecs[i].vmode, vecs[i].rdy_low);
         drain();
         chk({vecs[i].name, "_writes"}, 64'(obs_wr), 64'(vecs[i].exp_wr));
         chk({vecs[i].name, "_commits"}, 64'(obs_cm), 64'(vecs[i].exp_cm));
         chk({vecs[i].name, "_errs"}, 64'(obs_err), 64'(vecs[i].exp_err));
         chk({vecs[i].name, "_frame_done"}, 64'(obs_fd), 64'(vecs[i].exp_fd));
      end

      // Row turnaround: commit two cycles after the last pixel, refill at three
      do_reset();
      drive_pixels(16, 0, 0, 0);
      drain();
      chk("ta_accepts", 64'(acc_cyc.size()), 64'(16));
      chk("ta_stores", 64'(store_cyc.size()), 64'(2));
      if (acc_cyc.size() == 16 && store_cyc.size() == 2) begin
         chk("ta_back_to_back", 64'(acc_cyc[1] - acc_cyc[0]), 64'(1));
         chk("ta_commit_lat0", 64'(store_cyc[0] - acc_cyc[7]), 64'(2));
         chk("ta_refill_gap", 64'(acc_cyc[8] - acc_cyc[7]), 64'(3));
         chk("ta_commit_lat1", 64'(store_cyc[1] - acc_cyc[15]), 64'(2));
      end

      // Backpressure: write-in stage busy for 20 cycles after line 0
      do_reset();
      drive_pixels(8, 0, 0, 1000);
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_wr_en", 64'(wr_en), 64'(0));
         chk("bp_store", 64'(wr_row_store), 64'(0));
      end
      wr_row_rdy = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_commit", 64'(wr_row_store), 64'(1));
      @(negedge clk);
      chk("bp_refill", 64'(in_ready), 64'(1));
      drain();

      // Reset mid-line at column 5
      do_reset();
      drive_pixels(5, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_clear();
      #1 check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_rdy_low", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1 chk("midrst_rdy_rise", 64'(in_ready), 64'(1));
      drive_pixels(1, -1, 0, 0);
      drain();
      chk("midrst_col", 64'(last_wr_col), 64'(0));
      chk("midrst_writes", 64'(obs_wr), 64'(1));
      chk("midrst_no_commit", 64'(obs_cm), 64'(0));

      // Pixel format check on a fixed value
`ifdef HUB75_STREAM_RGB565_EN
      pix = 16'hF81F;
      pix_exp = 24'hFF00FF;
`else
      pix = 24'h5A3C96;
      pix_exp = 24'h5A3C96;
`endif
      do_reset();
      @(negedge clk);
      in_data = pix;
      in_sof = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 10 && !in_ready; k++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof = 1'b0;
      chk("fmt_wr_en", 64'(wr_en), 64'(1));
      chk("fmt_wr_data", 64'(wr_data), 64'(pix_exp));
      drain();

      // Randomized traffic against the model
      for (int r = 0; r < 4; r++) begin
         do_reset();
         drive_pixels(150, $urandom_range(0, 149), 2, -1);
         drain();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hub75_stream_writer.md
# hub75_stream_writer

Upstream feeder for the HUB75 frame-buffer write-in stage. Accepts a raster-ordered pixel stream (valid/ready, start-of-frame flag) and writes each pixel into the write-in stage's double-buffered line buffer. It tracks column, row and bank position. When a line is complete, it waits for the write-in stage to become free, then issues the buffer swap and row store. It also detects stream sync errors and resynchronises on start-of-frame.

## Interface
Parameters:
- N_BANKS, 2, number of panel banks (vertical sections)
- N_ROWS, 32, rows per bank (power of 2)
- N_COLS, 64, pixels per line (power of 2, ≥ 2)
- N_CHANS, 3, colour channels
- N_PLANES, 8, bits per channel
- LOG_N_BANKS / LOG_N_ROWS / LOG_N_COLS, $clog2 of the above, auto-set

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  N_CHANS*N_PLANES  pixel, channel 0 in LSBs (16 bits with RGB565 option)
- in_sof  in  1  marks first pixel of a frame; qualified by in_valid
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready
- wr_bank_addr  out  LOG_N_BANKS  bank of the line being committed
- wr_row_addr  out  LOG_N_ROWS  row of the line being committed
- wr_row_store  out  1  one-cycle commit pulse
- wr_row_rdy  in  1  write-in stage idle, commit allowed
- wr_row_swap  out  1  one-cycle line-buffer swap pulse, coincident with wr_row_store
- wr_data  out  N_CHANS*N_PLANES  pixel to line buffer
- wr_col_addr  out  LOG_N_COLS  column of wr_data
- wr_en  out  1  line-buffer write strobe
- frame_done  out  1  one-cycle pulse when the last line of a frame is committed
- err_sync  out  1  one-cycle pulse on start-of-frame misalignment

## Operation
- Line index y ranges over 0..N_BANKS*N_ROWS-1. wr_bank_addr = y[MSBs] and wr_row_addr = y[LOG_N_ROWS-1:0].
- FSM states:
  - FILL: in_ready=1. Each accepted pixel is written at the current column, and the column counter increments. Accepting column N_COLS-1 moves to WAIT.
  - WAIT: in_ready=0. Moves to COMMIT on the first cycle wr_row_rdy=1, with a minimum of one cycle in WAIT.
  - COMMIT: one cycle. Asserts wr_row_swap=wr_row_store=1 with y stable. At the end of the cycle, y increments (wrapping to 0 after the last line) and the FSM returns to FILL. frame_done is asserted in the same cycle when y was the last line.
- Column counter wraps to 0 at COMMIT.
- in_sof on an accepted pixel forces that pixel to column 0 of line 0, then continues normally.
  - If the position was not (col 0, y 0), err_sync pulses one cycle after acceptance.
  - in_sof at (0,0) is silent.
- Pixels without in_sof are never dropped. A short frame simply runs into the next one.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_row_store=0, wr_row_swap=0, frame_done=0, err_sync=0. Counters are 0, state is FILL. wr_data, wr_col_addr, wr_bank_addr and wr_row_addr reset to 0.
- in_ready is registered and goes to 1 on the first clk edge after rst_n deasserts.
- Write latency: a pixel accepted at cycle t appears as wr_en/wr_data/wr_col_addr at t+1.
- Row turnaround:
  - The last pixel is accepted at t, WAIT occupies t+1 and onward, and COMMIT is at t+2 at the earliest (wr_row_rdy high at t+1).
  - FILL resumes at t+3, so the minimum cost is 2 dead cycles per line.
  - The last write (t+1) always precedes the swap.
- No swap or store is ever issued while wr_row_rdy=0.
- rst_n asserted mid-line discards the partial line. No store or swap is emitted.

## Configuration
- HUB75_STREAM_RGB565_EN
  - Defined: in_data is 16 bits RGB565 (R in [15:11]). It is expanded to 8 bits per channel by MSB replication (R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8 likewise) into wr_data {B,G,R}. Requires N_CHANS=3 and N_PLANES=8.
  - Undefined: in_data is passed through unchanged.

## Test plan
All scenarios use N_BANKS=2, N_ROWS=4, N_COLS=8.
- Full frame: continuous valid and wr_row_rdy=1, 64 pixels with in_sof on the first.
  - Required: 8 commits with (bank,row) = (0,0)..(0,3),(1,0)..(1,3), each after 8 writes to cols 0..7.
  - frame_done pulses on the 8th commit.
  - 2 idle cycles per line.
- Backpressure: hold wr_row_rdy=0 for 20 cycles after line 0.
  - Required: in_ready stays 0 and no wr_en fires.
  - COMMIT occurs the cycle after wr_row_rdy rises.
- Gapped valid: in_valid toggles every cycle.
  - Required: wr_col_addr increments only on accepted pixels, and data matches the input sequence.
- Resync: in_sof on the 3rd pixel of line 2.
  - Required: err_sync pulses once, that pixel lands at y=0 col 0, and no commit is issued for the partial line.
- Reset: rst_n low mid-line at col 5, then release.
  - Required: all outputs are 0 during reset, in_ready rises after 1 edge, and the next pixel is written to col 0, y 0.
- RGB565 (macro defined): in_data=16'hF81F.
  - Required: wr_data=24'hFF00FF.
